// File: rtl/alu_flag_unit.sv
// alu_flag_unit: registered status flags (Z, C, N, V) for the ALU datapath,
// with sticky accumulated copies and a saturating overflow-event counter.
module alu_flag_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_raw,
  input  logic             sticky_clr,
  input  logic             cnt_clr,
  output logic             valid_out,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [2:0] {
    OP_SUM   = 3'd0,
    OP_RES   = 3'd1,
    OP_PRO   = 3'd2,
    OP_ANDS  = 3'd3,
    OP_ORS   = 3'd4,
    OP_NANDS = 3'd5,
    OP_NORS  = 3'd6,
    OP_XORS  = 3'd7
  } opcodeE;

  logic             validQ;
  logic             zeroQ, carryQ, negQ, ovfQ;
  logic             zeroD, carryD, negD, ovfD;
  logic [3:0]       stickyQ, stickyD, stickyBase;
  logic [CNT_W-1:0] cntQ, cntD, cntBase;
  logic             aMsb, bMsb, rMsb;

  assign aMsb = op_a[WIDTH-1];
  assign bMsb = op_b[WIDTH-1];
  assign rMsb = result[WIDTH-1];

  // Flags for the operation currently on the inputs; carry and overflow only
  // mean something for the arithmetic opcodes.
  always_comb begin
    zeroD  = (result == '0);
    negD   = rMsb;
    carryD = 1'b0;
    ovfD   = 1'b0;
    case (opcodeE'(opcode))
      OP_SUM: begin
        carryD = carry_raw;
        ovfD   = (aMsb == bMsb) && (rMsb != aMsb);
      end
      OP_RES: begin
        carryD = carry_raw;
        ovfD   = (aMsb != bMsb) && (rMsb != aMsb);
      end
      OP_PRO: begin
        carryD = carry_raw;
      end
      default: begin
        carryD = 1'b0;
        ovfD   = 1'b0;
      end
    endcase
  end

  // Sticky flags: a clear wipes history, a new operation is OR-ed in on top,
  // so clear plus operation in one cycle leaves just the new flags.
  always_comb begin
    stickyBase = sticky_clr ? 4'b0000 : stickyQ;
    stickyD    = stickyBase;
    if (valid_in) begin
      stickyD = stickyBase | {ovfD, negD, carryD, zeroD};
    end
  end

  // Overflow counter: clear first, then count the new event unless already
  // at all-ones, so the count saturates instead of wrapping.
  always_comb begin
    cntBase = cnt_clr ? '0 : cntQ;
    cntD    = cntBase;
    if (valid_in && ovfD && (cntBase != '1)) begin
      cntD = cntBase + CNT_W'(1);
    end
  end

  // State registers; flags only move on an accepted operation so that
  // undriven operands during idle cycles never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ  <= 1'b0;
      zeroQ   <= 1'b0;
      carryQ  <= 1'b0;
      negQ    <= 1'b0;
      ovfQ    <= 1'b0;
      stickyQ <= 4'b0000;
      cntQ    <= '0;
    end else begin
      validQ  <= valid_in;
      stickyQ <= stickyD;
      cntQ    <= cntD;
      if (valid_in) begin
        zeroQ  <= zeroD;
        carryQ <= carryD;
        negQ   <= negD;
        ovfQ   <= ovfD;
      end
    end
  end

  assign valid_out    = validQ;
  assign zero_flag    = zeroQ;
  assign carry_flag   = carryQ;
  assign neg_flag     = negQ;
  assign ovf_flag     = ovfQ;
  assign sticky_flags = stickyQ;
  assign ovf_count    = cntQ;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb_alu_flag_unit: directed and random checks of alu_flag_unit against a
// behavioural model; a second instance with a 2-bit counter covers saturation.
module tb_alu_flag_unit;

  localparam logic [2:0] SUM = 3'd0, RES = 3'd1, PRO = 3'd2, ANDS = 3'd3,
                         ORS = 3'd4, NANDS = 3'd5, NORS = 3'd6, XORS = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] op_a = 8'h00, op_b = 8'h00, result = 8'h00;
  logic       carry_raw = 1'b0, sticky_clr = 1'b0, cnt_clr = 1'b0;

  logic       validOut, zeroFlag, carryFlag, negFlag, ovfFlag;
  logic [3:0] stickyFlags;
  logic [7:0] ovfCount;
  logic       validOut2, zeroFlag2, carryFlag2, negFlag2, ovfFlag2;
  logic [3:0] stickyFlags2;
  logic [1:0] ovfCount2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit cmpEn  = 1'b0;

  // Reference state: plain integers and bits derived from the flag rules.
  bit       mValid, mZ, mC, mN, mV;
  bit [3:0] mSticky;
  int       mCnt8, mCnt2;

  alu_flag_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .result(result), .carry_raw(carry_raw),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .valid_out(validOut), .zero_flag(zeroFlag), .carry_flag(carryFlag),
    .neg_flag(negFlag), .ovf_flag(ovfFlag), .sticky_flags(stickyFlags),
    .ovf_count(ovfCount)
  );

  alu_flag_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .result(result), .carry_raw(carry_raw),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .valid_out(validOut2), .zero_flag(zeroFlag2), .carry_flag(carryFlag2),
    .neg_flag(negFlag2), .ovf_flag(ovfFlag2), .sticky_flags(stickyFlags2),
    .ovf_count(ovfCount2)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Hand-computed expectation for {V,N,C,Z} and valid_out of the main instance.
  task automatic checkOutput(input string name, input logic [3:0] vncz, input logic vld);
    checkVal({name, " vncz"}, {28'd0, ovfFlag, negFlag, carryFlag, zeroFlag}, {28'd0, vncz});
    checkVal({name, " valid"}, {31'd0, validOut}, {31'd0, vld});
  endtask

  // Drive one cycle of inputs just after a falling edge and wait for the next
  // falling edge, by which time the rising edge has consumed them.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] r, input logic cr,
                               input logic sclr, input logic cclr);
    #1;
    valid_in = v; opcode = op; op_a = a; op_b = b; result = r;
    carry_raw = cr; sticky_clr = sclr; cnt_clr = cclr;
    @(negedge clk);
  endtask

  // Idle cycle with undefined operand data.
  task automatic idleCycle();
    #1;
    valid_in = 1'b0; opcode = 3'bx; op_a = 8'hxx; op_b = 8'hxx; result = 8'hxx;
    carry_raw = 1'bx; sticky_clr = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
  endtask

  // Behavioural model: evaluate the flag rules on the sampled inputs.
  always @(posedge clk or posedge rst) begin
    bit z, c, n, v;
    int base8, base2;
    if (rst) begin
      mValid = 0; mZ = 0; mC = 0; mN = 0; mV = 0; mSticky = 0; mCnt8 = 0; mCnt2 = 0;
    end else begin
      z = (result == 8'd0);
      n = result[7];
      c = (opcode <= PRO) ? carry_raw : 1'b0;
      if (opcode == SUM)      v = (op_a[7] == op_b[7]) && (result[7] != op_a[7]);
      else if (opcode == RES) v = (op_a[7] != op_b[7]) && (result[7] != op_a[7]);
      else                    v = 0;
      mValid = valid_in;
      if (sticky_clr) mSticky = 4'b0000;
      base8 = cnt_clr ? 0 : mCnt8;
      base2 = cnt_clr ? 0 : mCnt2;
      if (valid_in) begin
        mZ = z; mC = c; mN = n; mV = v;
        mSticky = mSticky | {v, n, c, z};
        if (v && base8 < 255) base8++;
        if (v && base2 < 3)   base2++;
      end
      mCnt8 = base8;
      mCnt2 = base2;
    end
  end

  // Compare process: every falling edge once out of the initial reset.
  initial begin
    wait (cmpEn);
    forever begin
      @(negedge clk);
      checkVal("m.valid",  {31'd0, validOut}, {31'd0, mValid});
      checkVal("m.vncz",   {28'd0, ovfFlag, negFlag, carryFlag, zeroFlag}, {28'd0, mV, mN, mC, mZ});
      checkVal("m.sticky", {28'd0, stickyFlags}, {28'd0, mSticky});
      checkVal("m.cnt8",   {24'd0, ovfCount}, mCnt8);
      checkVal("m.cnt2",   {30'd0, ovfCount2}, mCnt2);
      checkVal("m.vncz2",  {27'd0, validOut2, ovfFlag2, negFlag2, carryFlag2, zeroFlag2},
               {27'd0, mValid, mV, mN, mC, mZ});
    end
  end

  // Directed scenarios followed by a random back-to-back stream.
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmpEn = 1'b1;

    // Reset check: build up state, then assert reset mid-cycle.
    applyStimulus(1, SUM, 8'h7F, 8'h01, 8'h80, 1'b1, 0, 0);
    checkOutput("pre-reset", 4'b1110, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset", 4'b0000, 1'b0);
    checkVal("async reset sticky", {28'd0, stickyFlags}, 32'd0);
    checkVal("async reset cnt", {24'd0, ovfCount}, 32'd0);
    valid_in = 1'b1; opcode = SUM; op_a = 8'h7F; op_b = 8'h01; result = 8'h80; carry_raw = 1'b1;
    @(negedge clk);
    checkOutput("op during reset", 4'b0000, 1'b0);
    rst = 1'b0;
    applyStimulus(1, SUM, 8'h7F, 8'h01, 8'h80, 1'b0, 0, 0);
    checkOutput("sum 7F+01", 4'b1100, 1'b1);
    checkVal("sum 7F+01 cnt", {24'd0, ovfCount}, 32'd1);

    // SUM carry/zero, then RES overflow.
    applyStimulus(1, SUM, 8'hFF, 8'h01, 8'h00, 1'b1, 0, 0);
    checkOutput("sum FF+01", 4'b0011, 1'b1);
    applyStimulus(1, RES, 8'h80, 8'h01, 8'h7F, 1'b0, 0, 0);
    checkOutput("res 80-01", 4'b1000, 1'b1);

    // Logic opcodes, then hold across idle cycles with undefined data.
    applyStimulus(1, XORS, 8'h55, 8'h55, 8'h00, 1'b1, 0, 0);
    checkOutput("xors", 4'b0001, 1'b1);
    applyStimulus(1, NORS, 8'h00, 8'h7F, 8'h80, 1'b0, 0, 0);
    checkOutput("nors", 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("idle hold", 4'b0100, 1'b0);
    end

    // Sticky accumulation and clear-with-operation.
    applyStimulus(1, ANDS, 8'h0F, 8'hF0, 8'h00, 1'b1, 1, 0);
    checkVal("sticky Z", {28'd0, stickyFlags}, 32'b0001);
    applyStimulus(1, ORS, 8'h80, 8'h00, 8'h80, 1'b0, 0, 0);
    checkVal("sticky ZN", {28'd0, stickyFlags}, 32'b0101);
    applyStimulus(1, SUM, 8'h01, 8'h01, 8'h02, 1'b1, 0, 0);
    checkVal("sticky ZNC", {28'd0, stickyFlags}, 32'b0111);
    applyStimulus(1, SUM, 8'h80, 8'h80, 8'h01, 1'b0, 1, 0);
    checkVal("sticky clr+V", {28'd0, stickyFlags}, 32'b1000);

    // Counter saturation on the 2-bit instance.
    applyStimulus(0, SUM, 8'h00, 8'h00, 8'h00, 1'b0, 0, 1);
    checkVal("cnt2 cleared", {30'd0, ovfCount2}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, SUM, 8'h7F, 8'h01, 8'h80, 1'b0, 0, 0);
      checkVal("cnt2 step", {30'd0, ovfCount2}, (i < 3) ? i + 1 : 3);
    end
    applyStimulus(1, SUM, 8'h7F, 8'h01, 8'h80, 1'b0, 0, 1);
    checkVal("cnt2 clr+ovf", {30'd0, ovfCount2}, 32'd1);
    applyStimulus(0, SUM, 8'h7F, 8'h01, 8'h80, 1'b0, 0, 1);
    checkVal("cnt2 clr", {30'd0, ovfCount2}, 32'd0);

    // Random back-to-back stream with occasional clears and reset pulses.
    for (int i = 0; i < 1000; i++) begin
      #1;
      rst        = ($urandom_range(0, 99) == 0);
      valid_in   = ($urandom_range(0, 3) != 0);
      opcode     = 3'($urandom_range(0, 7));
      op_a       = 8'($urandom);
      op_b       = 8'($urandom);
      result     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      carry_raw  = 1'($urandom);
      sticky_clr = ($urandom_range(0, 15) == 0);
      cnt_clr    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    #1 rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Parametrised, registered status-flag unit for the ALU datapath. Each accepted operation produces four flags from the operands, the result and the raw carry supplied by the datapath: zero, carry, negative and overflow. The unit also keeps sticky (accumulated) copies of the flags and a saturating overflow-event counter. It sits after the ALU result multiplexer and feeds the status register and the control logic.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- CNT_W, 8, overflow-event counter width in bits (≥1)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  operation sample strobe; inputs are captured only when this is 1
- opcode  in  3  SUM=0, RES=1, PRO=2, ANDS=3, ORS=4, NANDS=5, NORS=6, XORS=7
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- result  in  WIDTH  ALU result for opcode
- carry_raw  in  1  datapath carry: SUM carry-out, RES borrow, PRO high-half-nonzero
- sticky_clr  in  1  clears the sticky flags
- cnt_clr  in  1  clears the overflow counter
- valid_out  out  1  pulses one cycle after an accepted valid_in
- zero_flag  out  1  registered Z
- carry_flag  out  1  registered C
- neg_flag  out  1  registered N
- ovf_flag  out  1  registered V
- sticky_flags  out  4  accumulated flags {V,N,C,Z}
- ovf_count  out  CNT_W  saturating count of operations with V=1

## Operation
- Flag computation is combinational on the inputs and is registered only when valid_in=1:
  - Z = (result == 0), for all opcodes
  - N = result[WIDTH-1], for all opcodes
  - C = carry_raw for SUM, RES and PRO; 0 for the logic opcodes (3–7)
  - V for SUM = (a_msb == b_msb) && (result_msb != a_msb)
  - V for RES = (a_msb != b_msb) && (result_msb != a_msb)
  - V = 0 for all other opcodes
- valid_in=0: zero/carry/neg/ovf hold their last values; sticky_flags and ovf_count hold unless a clear is applied.
- Sticky update each cycle: next = (sticky_clr ? 0 : sticky_flags) | (valid_in ? {V,N,C,Z} : 0). A clear and a new operation in the same cycle give only the new operation's flags.
- Counter update each cycle:
  - base = cnt_clr ? 0 : ovf_count
  - next = base + 1 when valid_in && V && base != all-ones; otherwise next = base
  - A clear and an overflow in the same cycle give a count of 1.
  - The counter saturates at 2^CNT_W−1 and never wraps.
- No state machine is needed beyond the registers. The unit is fully pipelined and accepts one operation per cycle, back to back.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k appear on the flag outputs and on valid_out after edge k.
- valid_out is 1 for exactly the cycle after each accepted valid_in. Back-to-back valid_in gives a continuous valid_out.
- sticky_clr and cnt_clr take effect at the next edge and are independent of valid_in.
- Reset: every output goes to 0 immediately on rst assertion, regardless of clk. This covers valid_out, all four flags, sticky_flags and ovf_count.
- Reset mid-stream: an operation captured in the same cycle as rst assertion is discarded. The first edge after rst deassertion samples normally.
- X on op_a, op_b, result or carry_raw while valid_in=0 must not propagate to any output.

## Test plan
- Reset check, WIDTH=8: assert rst mid-cycle after non-zero state. All outputs read 0 before the next edge. Then apply SUM with a=0x7F, b=0x01, result=0x80, carry_raw=0. Next cycle: N=1, V=1, C=0, Z=0, valid_out=1, ovf_count=1.
- SUM carry/zero: a=0xFF, b=0x01, result=0x00, carry_raw=1 gives Z=1, C=1, N=0, V=0. Then RES a=0x80, b=0x01, result=0x7F, carry_raw=0 gives V=1, N=0, C=0.
- Logic opcodes: XORS a=0x55, b=0x55, result=0x00, carry_raw=1 gives Z=1, C=0, V=0. Then NORS result=0x80 gives N=1, Z=0. Then drop valid_in for 3 cycles: flags hold and valid_out stays 0.
- Sticky: apply Z-only, then N-only, then C-only operations. sticky_flags goes 0001, 0101, 0111. Next, sticky_clr together with a V-only SUM operation gives 1000.
- Counter saturation, CNT_W=2: apply 5 consecutive overflowing SUMs. ovf_count steps 1, 2, 3, 3, 3. Then cnt_clr together with an overflowing SUM gives 1. Then cnt_clr alone gives 0.
- Back-to-back random: 1000 random opcodes and operands with random valid_in. Compare against a reference model every cycle, including valid_out and a randomly pulsed rst.
